// File: rtl/icache_downstream_bridge.sv
// icache_downstream_bridge
// Bridges icache miss-refill requests to the memory fabric and returns refill
// data to the icache. Requests are buffered in a small FIFO, in-flight ids are
// tracked in a busy bitmap, and returning data passes through a one-entry
// response register. Duplicate ids stall, total in-flight traffic is capped,
// and responses carrying an id that is not outstanding raise a sticky flag.
module icache_downstream_bridge #(
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int DATA_W    = 256,
  parameter int REQ_DEPTH = 4,
  parameter int MAX_OUT   = 8,
  localparam int CNT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // icache request side
  input  logic                     downstream_txreq_vld,
  output logic                     downstream_txreq_rdy,
  input  logic [ADDR_W-1:0]        downstream_txreq_pld,
  input  logic [ID_W-1:0]          downstream_txreq_entry_id,
  // fabric request side
  output logic                     fab_req_vld,
  input  logic                     fab_req_rdy,
  output logic [ADDR_W-1:0]        fab_req_addr,
  output logic [ID_W-1:0]          fab_req_txnid,
  // fabric response side
  input  logic                     fab_rsp_vld,
  output logic                     fab_rsp_rdy,
  input  logic [DATA_W-1:0]        fab_rsp_data,
  input  logic [ID_W-1:0]          fab_rsp_txnid,
  // icache response side
  output logic                     downstream_rxdat_vld,
  input  logic                     downstream_rxdat_rdy,
  output logic [DATA_W+ID_W-1:0]   downstream_rxdat_pld,
  // status
  output logic [CNT_W-1:0]         outstanding_cnt,
  output logic                     err_unexp_rsp
);

  localparam int PTR_W  = $clog2(REQ_DEPTH) + 1;
  localparam int IDX_W  = PTR_W - 1;
  localparam int NUM_ID = 1 << ID_W;

  // request FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ADDR_W-1:0] fifo_addr_q [REQ_DEPTH];
  logic [ID_W-1:0]   fifo_id_q   [REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              fifo_full, fifo_empty;

  // in-flight tracking
  logic [NUM_ID-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // response register
  logic              rsp_full_q, rsp_full_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  // holds fab_rsp_rdy low while reset is applied and for the first edge after
  logic              rsp_en_q;

  // handshakes
  logic push, pop, rsp_take, retire, retire_known, cnt_dec;

  assign wr_idx     = wr_ptr_q[IDX_W-1:0];
  assign rd_idx     = rd_ptr_q[IDX_W-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // full flag is the pre-pop value, so a full FIFO never takes a push even when
  // the head is leaving in the same cycle
  assign downstream_txreq_rdy = !fifo_full &&
                                (cnt_q < CNT_W'(MAX_OUT)) &&
                                !busy_q[downstream_txreq_entry_id];

  assign fab_req_vld   = !fifo_empty;
  assign fab_req_addr  = fifo_addr_q[rd_idx];
  assign fab_req_txnid = fifo_id_q[rd_idx];

  assign fab_rsp_rdy          = rsp_en_q && (!rsp_full_q || downstream_rxdat_rdy);
  assign downstream_rxdat_vld = rsp_full_q;
  assign downstream_rxdat_pld = {rsp_id_q, rsp_data_q};

  assign outstanding_cnt = cnt_q;
  assign err_unexp_rsp   = err_q;

  assign push         = downstream_txreq_vld && downstream_txreq_rdy;
  assign pop          = fab_req_vld && fab_req_rdy;
  assign rsp_take     = fab_rsp_vld && fab_rsp_rdy;
  assign retire       = rsp_full_q && downstream_rxdat_rdy;
  // retiring a response that was never outstanding leaves the count alone
  assign retire_known = retire && busy_q[rsp_id_q];
  assign cnt_dec      = retire_known && (cnt_q != '0);

  // FIFO pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // busy bitmap, in-flight count and sticky error next-state
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (retire) busy_d[rsp_id_q] = 1'b0;
    if (push)   busy_d[downstream_txreq_entry_id] = 1'b1;
    case ({push, cnt_dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (rsp_take && !busy_q[fab_rsp_txnid]) err_d = 1'b1;
  end

  // response register next-state: refill-on-drain keeps one response per cycle
  always_comb begin
    rsp_full_d = rsp_full_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (rsp_take) begin
      rsp_full_d = 1'b1;
      rsp_id_d   = fab_rsp_txnid;
      rsp_data_d = fab_rsp_data;
    end else if (retire) begin
      rsp_full_d = 1'b0;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
    end else if (push) begin
      fifo_addr_q[wr_idx] <= downstream_txreq_pld;
      fifo_id_q[wr_idx]   <= downstream_txreq_entry_id;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rsp_full_q <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_en_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rsp_full_q <= rsp_full_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_en_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_downstream_bridge.sv
// Bench for icache_downstream_bridge: directed scenarios followed by random
// traffic, every cycle compared against a queue-based transaction model.
module tb_icache_downstream_bridge;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 4;
  localparam int MAXO   = 8;
  localparam int CNT_W  = $clog2(MAXO + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   txreq_vld, txreq_rdy;
  logic [ADDR_W-1:0]      txreq_pld;
  logic [ID_W-1:0]        txreq_id;
  logic                   fab_req_vld, fab_req_rdy;
  logic [ADDR_W-1:0]      fab_req_addr;
  logic [ID_W-1:0]        fab_req_txnid;
  logic                   fab_rsp_vld, fab_rsp_rdy;
  logic [DATA_W-1:0]      fab_rsp_data;
  logic [ID_W-1:0]        fab_rsp_txnid;
  logic                   rxdat_vld, rxdat_rdy;
  logic [DATA_W+ID_W-1:0] rxdat_pld;
  logic [CNT_W-1:0]       out_cnt;
  logic                   err_unexp;

  icache_downstream_bridge #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .REQ_DEPTH(DEPTH), .MAX_OUT(MAXO)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .downstream_txreq_vld      (txreq_vld),
    .downstream_txreq_rdy      (txreq_rdy),
    .downstream_txreq_pld      (txreq_pld),
    .downstream_txreq_entry_id (txreq_id),
    .fab_req_vld               (fab_req_vld),
    .fab_req_rdy               (fab_req_rdy),
    .fab_req_addr              (fab_req_addr),
    .fab_req_txnid             (fab_req_txnid),
    .fab_rsp_vld               (fab_rsp_vld),
    .fab_rsp_rdy               (fab_rsp_rdy),
    .fab_rsp_data              (fab_rsp_data),
    .fab_rsp_txnid             (fab_rsp_txnid),
    .downstream_rxdat_vld      (rxdat_vld),
    .downstream_rxdat_rdy      (rxdat_rdy),
    .downstream_rxdat_pld      (rxdat_pld),
    .outstanding_cnt           (out_cnt),
    .err_unexp_rsp             (err_unexp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // transaction-level model
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
  } req_t;
  req_t              mq[$];
  logic [ID_W-1:0]   fab_q[$];
  bit   [15:0]       m_busy;
  int                m_cnt;
  bit                m_rsp_full;
  logic [ID_W-1:0]   m_rsp_id;
  logic [DATA_W-1:0] m_rsp_data;
  bit                m_err;
  bit                m_en;

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    fab_q.delete();
    m_busy = '0; m_cnt = 0; m_rsp_full = 0; m_rsp_id = '0;
    m_rsp_data = '0; m_err = 0; m_en = 0;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // one clock cycle: drive, compare against the model, clock, update the model
  task automatic step(input bit txv, input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                      input bit frr, input bit rspv, input logic [ID_W-1:0] rspid,
                      input logic [DATA_W-1:0] rdata, input bit rxr);
    bit exp_txrdy, exp_frsprdy, acc, pop, cap, ret;
    int k;
    txreq_vld = txv; txreq_pld = addr; txreq_id = id; fab_req_rdy = frr;
    fab_rsp_vld = rspv; fab_rsp_txnid = rspid; fab_rsp_data = rdata; rxdat_rdy = rxr;
    #2;
    exp_txrdy   = (mq.size() < DEPTH) && (m_cnt < MAXO) && !m_busy[id];
    exp_frsprdy = m_en && (!m_rsp_full || rxr);
    chk("txreq_rdy", txreq_rdy, exp_txrdy);
    chk("fab_req_vld", fab_req_vld, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("fab_req_addr", fab_req_addr, mq[0].addr);
      chk("fab_req_txnid", fab_req_txnid, mq[0].id);
    end
    chk("fab_rsp_rdy", fab_rsp_rdy, exp_frsprdy);
    chk("rxdat_vld", rxdat_vld, m_rsp_full);
    if (m_rsp_full) chk("rxdat_pld", rxdat_pld, {m_rsp_id, m_rsp_data});
    chk("outstanding_cnt", out_cnt, m_cnt);
    chk("err_unexp_rsp", err_unexp, m_err);
    @(posedge clk);
    acc = txv && exp_txrdy;
    pop = (mq.size() > 0) && frr;
    cap = rspv && exp_frsprdy;
    ret = m_rsp_full && rxr;
    if (cap && !m_busy[rspid]) m_err = 1;
    if (ret && m_busy[m_rsp_id]) begin
      m_busy[m_rsp_id] = 0;
      m_cnt--;
    end
    if (pop) begin
      fab_q.push_back(mq[0].id);
      void'(mq.pop_front());
    end
    if (acc) begin
      mq.push_back('{addr, id});
      m_busy[id] = 1;
      m_cnt++;
    end
    if (cap) begin
      m_rsp_full = 1; m_rsp_id = rspid; m_rsp_data = rdata;
      k = -1;
      for (int j = 0; j < fab_q.size(); j++) if (k < 0 && fab_q[j] == rspid) k = j;
      if (k >= 0) fab_q.delete(k);
    end else if (ret) begin
      m_rsp_full = 0;
    end
    m_en = 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_txreq_rdy", txreq_rdy, 1'b1);
    chk("rst_fab_req_vld", fab_req_vld, 1'b0);
    chk("rst_fab_req_addr", fab_req_addr, '0);
    chk("rst_fab_req_txnid", fab_req_txnid, '0);
    chk("rst_fab_rsp_rdy", fab_rsp_rdy, 1'b0);
    chk("rst_rxdat_vld", rxdat_vld, 1'b0);
    chk("rst_rxdat_pld", rxdat_pld, '0);
    chk("rst_cnt", out_cnt, '0);
    chk("rst_err", err_unexp, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d5, d3, d7, da5;
    logic [ADDR_W-1:0] a;
    bit rv, tv, fr, rr;
    logic [ID_W-1:0] rid;

    rst_n = 0;
    txreq_vld = 0; txreq_pld = '0; txreq_id = '0; fab_req_rdy = 0;
    fab_rsp_vld = 0; fab_rsp_txnid = '0; fab_rsp_data = '0; rxdat_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1;
    idle(2);

    // single miss
    da5 = {32{8'hA5}};
    step(1, 32'h1000, 4'd3, 0, 0, '0, '0, 0);
    chk("miss_fab_vld_n1", fab_req_vld, 1'b1);
    chk("miss_fab_addr", fab_req_addr, 32'h1000);
    chk("miss_cnt1", out_cnt, 1);
    step(0, '0, '0, 1, 0, '0, '0, 0);
    idle(4);
    step(0, '0, '0, 0, 1, 4'd3, da5, 0);
    chk("miss_rxdat_vld", rxdat_vld, 1'b1);
    chk("miss_rxdat_pld", rxdat_pld, {4'd3, da5});
    step(0, '0, '0, 0, 0, '0, '0, 1);
    chk("miss_cnt0", out_cnt, 0);

    // duplicate id stall
    step(1, 32'h2000, 4'd2, 0, 0, '0, '0, 0);
    step(0, '0, '0, 1, 0, '0, '0, 0);
    step(1, 32'h2040, 4'd2, 0, 0, '0, '0, 0);
    chk("dup_stall", txreq_rdy, 1'b0);
    step(1, 32'h2040, 4'd2, 0, 1, 4'd2, rnd_data(), 0);
    chk("dup_stall_rsp", txreq_rdy, 1'b0);
    step(1, 32'h2040, 4'd2, 0, 0, '0, '0, 1);
    chk("dup_release", txreq_rdy, 1'b1);
    step(1, 32'h2040, 4'd2, 0, 0, '0, '0, 0);
    chk("dup_accept_cnt", out_cnt, 1);
    step(0, '0, '0, 1, 0, '0, '0, 0);
    step(0, '0, '0, 0, 1, 4'd2, rnd_data(), 0);
    step(0, '0, '0, 0, 0, '0, '0, 1);

    // FIFO full
    for (int i = 0; i < 4; i++) step(1, $urandom, 4'(i), 0, 0, '0, '0, 0);
    chk("full_cnt4", out_cnt, 4);
    a = $urandom;
    step(1, a, 4'd4, 0, 0, '0, '0, 0);
    chk("full_stall", txreq_rdy, 1'b0);
    step(1, a, 4'd4, 1, 0, '0, '0, 0);
    chk("full_after_pop", txreq_rdy, 1'b1);
    step(1, a, 4'd4, 0, 0, '0, '0, 0);
    chk("full_cnt5", out_cnt, 5);

    // MAX_OUT cap
    for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0, '0, '0, 0);
    for (int i = 5; i < 8; i++) step(1, $urandom, 4'(i), 1, 0, '0, '0, 0);
    repeat (3) step(0, '0, '0, 1, 0, '0, '0, 0);
    chk("cap_cnt8", out_cnt, 8);
    chk("cap_fifo_empty", fab_req_vld, 1'b0);
    a = $urandom;
    step(1, a, 4'd8, 0, 0, '0, '0, 0);
    chk("cap_stall", txreq_rdy, 1'b0);
    step(0, '0, '0, 0, 1, 4'd0, rnd_data(), 0);
    step(0, '0, '0, 0, 0, '0, '0, 1);
    chk("cap_cnt7", out_cnt, 7);
    step(0, '0, '0, 0, 1, 4'd1, rnd_data(), 0);
    step(1, a, 4'd8, 0, 0, '0, '0, 1);
    chk("cap_swap_cnt", out_cnt, 7);
    chk("cap_swap_head", fab_req_txnid, 4'd8);

    // out-of-order responses with backpressure
    step(0, '0, '0, 1, 0, '0, '0, 0);
    d5 = rnd_data(); d3 = rnd_data(); d7 = rnd_data();
    step(0, '0, '0, 0, 1, 4'd5, d5, 1);
    step(0, '0, '0, 0, 1, 4'd3, d3, 0);
    chk("ooo_hold_pld", rxdat_pld, {4'd5, d5});
    chk("ooo_hold_rdy", fab_rsp_rdy, 1'b0);
    step(0, '0, '0, 0, 1, 4'd3, d3, 1);
    chk("ooo_pld3", rxdat_pld, {4'd3, d3});
    step(0, '0, '0, 0, 1, 4'd7, d7, 0);
    step(0, '0, '0, 0, 1, 4'd7, d7, 1);
    chk("ooo_pld7", rxdat_pld, {4'd7, d7});
    step(0, '0, '0, 0, 0, '0, '0, 1);
    chk("ooo_cnt4", out_cnt, 4);

    // unexpected response
    step(0, '0, '0, 0, 1, 4'd9, rnd_data(), 0);
    chk("unexp_err", err_unexp, 1'b1);
    chk("unexp_cnt", out_cnt, 4);
    step(0, '0, '0, 0, 0, '0, '0, 1);
    chk("unexp_retire_cnt", out_cnt, 4);
    idle(3);
    chk("unexp_sticky", err_unexp, 1'b1);

    // random traffic with a mid-run asynchronous reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        #2 rst_n = 0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
      end
      tv = ($urandom_range(0, 1) == 1);
      fr = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      rv = 0; rid = '0;
      if (fab_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rv = 1;
        rid = fab_q[$urandom_range(0, fab_q.size() - 1)];
      end else if ($urandom_range(0, 15) == 0) begin
        rv = 1;
        rid = 4'($urandom);
      end
      step(tv, $urandom, 4'($urandom), fr, rv, rid, rnd_data(), rr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
